// File: rtl/dispatch_alloc_ctrl.sv
// Dispatch allocation controller: in-order 3-wide dispatch gating against ROB,
// RS and freelist credit, with branch-recovery sequencing and a stall counter.
module dispatch_alloc_ctrl #(
   parameter int unsigned FL_DEPTH       = 32,
   parameter int unsigned CW             = 6,
   parameter int unsigned RECOVER_CYCLES = 2
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [2:0]    slot_valid,
   input  logic [2:0]    slot_dest,
   input  logic [CW-1:0] rob_free,
   input  logic [CW-1:0] rs_free,
   input  logic [CW-1:0] fl_distance,
   input  logic [1:0]    retire_count,
   input  logic          bp_recover_en,
   output logic [2:0]    slot_accept,
   output logic [2:0]    dispatch_en,
   output logic          stall,
   output logic [1:0]    state,
   output logic [CW-1:0] fl_credit,
   output logic [15:0]   stall_count
);

   localparam int unsigned RCW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
   localparam int unsigned SW  = CW + 1;
   localparam logic [RCW-1:0] RC_LOAD = RCW'(RECOVER_CYCLES - 1);
   localparam logic [CW-1:0]  DEPTH   = CW'(FL_DEPTH);

   typedef enum logic [1:0] {
      NORMAL  = 2'd0,
      RECOVER = 2'd1,
      RESYNC  = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [RCW-1:0]  rec_cnt_q, rec_cnt_d;
   logic [CW-1:0]   fl_credit_q, fl_credit_d;
   logic [15:0]     stall_count_q, stall_count_d;

   logic [2:0]      accept_c;
   logic [CW-1:0]   dest_cnt_c;
   logic            chain_c;
   logic            stall_c;
   logic [1:0]      pop_c;
   logic [SW-1:0]   credit_sum_c;

   // In-order acceptance: each slot needs its own resources plus all older slots accepted
   always_comb begin
      accept_c   = '0;
      dest_cnt_c = '0;
      chain_c    = (state_q == NORMAL) && !reset;
      for (int i = 0; i < 3; i++) begin
         dest_cnt_c  = dest_cnt_c + CW'(slot_dest[i]);
         chain_c     = chain_c && slot_valid[i]
                       && (rob_free >= CW'(i + 1))
                       && (rs_free  >= CW'(i + 1))
                       && (dest_cnt_c <= fl_credit_q);
         accept_c[i] = chain_c;
      end
   end

   assign slot_accept = accept_c;
   assign dispatch_en = accept_c & slot_dest;
   assign stall_c     = slot_valid[0] & ~accept_c[0];
   assign stall       = stall_c;

   // Net credit change; pop never exceeds current credit so no underflow
   always_comb begin
      pop_c        = 2'(dispatch_en[0]) + 2'(dispatch_en[1]) + 2'(dispatch_en[2]);
      credit_sum_c = SW'(fl_credit_q) + SW'(retire_count) - SW'(pop_c);
   end

   // Next-state logic: recovery sequencing, credit update, stall counting
   always_comb begin
      state_d       = state_q;
      rec_cnt_d     = rec_cnt_q;
      fl_credit_d   = fl_credit_q;
      stall_count_d = stall_count_q;

      case (state_q)
         NORMAL: begin
            fl_credit_d = (credit_sum_c > SW'(FL_DEPTH)) ? DEPTH : credit_sum_c[CW-1:0];
         end
         RECOVER: begin
            if (rec_cnt_q == '0) begin
               state_d = RESYNC;
            end else begin
               rec_cnt_d = rec_cnt_q - RCW'(1);
            end
         end
         RESYNC: begin
            fl_credit_d = (fl_distance > DEPTH) ? DEPTH : fl_distance;
            state_d     = NORMAL;
         end
         default: begin
            state_d = RESYNC;
         end
      endcase

      // A new mispredict always restarts recovery
      if (bp_recover_en) begin
         state_d   = RECOVER;
         rec_cnt_d = RC_LOAD;
      end

      if ((state_q == NORMAL) && stall_c && (stall_count_q != 16'hFFFF)) begin
         stall_count_d = stall_count_q + 16'd1;
      end
   end

   // State registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= RESYNC;
         rec_cnt_q     <= '0;
         fl_credit_q   <= '0;
         stall_count_q <= '0;
      end else begin
         state_q       <= state_d;
         rec_cnt_q     <= rec_cnt_d;
         fl_credit_q   <= fl_credit_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign state       = state_q;
   assign fl_credit   = fl_credit_q;
   assign stall_count = stall_count_q;

endmodule

// File: tb/tb_dispatch_alloc_ctrl.sv
// Directed self-checking bench for dispatch_alloc_ctrl (default parameters).
module tb_dispatch_alloc_ctrl;

   logic        clock;
   logic        reset;
   logic [2:0]  slot_valid;
   logic [2:0]  slot_dest;
   logic [5:0]  rob_free;
   logic [5:0]  rs_free;
   logic [5:0]  fl_distance;
   logic [1:0]  retire_count;
   logic        bp_recover_en;
   logic [2:0]  slot_accept;
   logic [2:0]  dispatch_en;
   logic        stall;
   logic [1:0]  state;
   logic [5:0]  fl_credit;
   logic [15:0] stall_count;

   int checks = 0;
   int errors = 0;

   dispatch_alloc_ctrl dut (
      .clock        (clock),
      .reset        (reset),
      .slot_valid   (slot_valid),
      .slot_dest    (slot_dest),
      .rob_free     (rob_free),
      .rs_free      (rs_free),
      .fl_distance  (fl_distance),
      .retire_count (retire_count),
      .bp_recover_en(bp_recover_en),
      .slot_accept  (slot_accept),
      .dispatch_en  (dispatch_en),
      .stall        (stall),
      .state        (state),
      .fl_credit    (fl_credit),
      .stall_count  (stall_count)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset         = 1'b1;
      slot_valid    = 3'b111;
      slot_dest     = 3'b111;
      rob_free      = 6'd8;
      rs_free       = 6'd8;
      fl_distance   = 6'd32;
      retire_count  = 2'd0;
      bp_recover_en = 1'b0;

      // Reset state
      step();
      #1 check("rst_accept", 32'(slot_accept), 32'h0);
      check("rst_disp", 32'(dispatch_en), 32'h0);
      step();
      check("rst_state", 32'(state), 32'd2);
      check("rst_credit", 32'(fl_credit), 32'd0);
      check("rst_stallcnt", 32'(stall_count), 32'd0);

      // First cycle out of reset is RESYNC, then full dispatch
      reset = 1'b0;
      #1 check("resync_accept", 32'(slot_accept), 32'h0);
      step();
      check("first_state", 32'(state), 32'd0);
      check("first_credit", 32'(fl_credit), 32'd32);
      check("first_accept", 32'(slot_accept), 32'h7);
      check("first_disp", 32'(dispatch_en), 32'h7);
      step();
      check("credit_29", 32'(fl_credit), 32'd29);

      // Recovery pulse with no dispatch
      slot_valid = 3'b000; bp_recover_en = 1'b1;
      step();
      bp_recover_en = 1'b0;
      check("rec1_state", 32'(state), 32'd1);
      slot_valid = 3'b111;
      #1 check("rec_accept", 32'(slot_accept), 32'h0);
      check("rec_disp", 32'(dispatch_en), 32'h0);
      check("rec_stall", 32'(stall), 32'd1);
      fl_distance = 6'd17;
      step();
      check("rec2_state", 32'(state), 32'd1);
      check("rec_credit_hold", 32'(fl_credit), 32'd29);
      step();
      check("resync_state", 32'(state), 32'd2);
      check("resync_accept2", 32'(slot_accept), 32'h0);
      step();
      check("post_rec_state", 32'(state), 32'd0);
      check("post_rec_credit", 32'(fl_credit), 32'd17);
      check("rec_no_stallcnt", 32'(stall_count), 32'd0);

      // Recover request in NORMAL still grants that cycle's dispatch
      bp_recover_en = 1'b1;
      #1 check("bp_grant", 32'(slot_accept), 32'h7);
      step();
      check("bp_credit", 32'(fl_credit), 32'd14);
      bp_recover_en = 1'b0; slot_valid = 3'b000; fl_distance = 6'd2;
      step();
      step();
      step();
      check("credit_2", 32'(fl_credit), 32'd2);

      // Credit-limited dispatch
      slot_valid = 3'b111; slot_dest = 3'b111;
      #1 check("cred2_accept", 32'(slot_accept), 32'h3);
      check("cred2_disp", 32'(dispatch_en), 32'h3);
      check("cred2_stall", 32'(stall), 32'd0);
      step();
      check("credit_0", 32'(fl_credit), 32'd0);

      // Zero credit, slot without destination passes
      slot_dest = 3'b010;
      #1 check("cred0_accept", 32'(slot_accept), 32'h1);
      check("cred0_disp", 32'(dispatch_en), 32'h0);
      step();
      slot_valid = 3'b000; retire_count = 2'd3;
      step();
      check("retire_3", 32'(fl_credit), 32'd3);

      // Same-cycle dispatch and retire netted
      slot_valid = 3'b111; slot_dest = 3'b111; retire_count = 2'd2;
      #1 check("net_accept", 32'(slot_accept), 32'h7);
      step();
      check("net_credit", 32'(fl_credit), 32'd2);
      slot_valid = 3'b000; retire_count = 2'd3;
      step();
      step();
      retire_count = 2'd2;
      step();
      retire_count = 2'd0;
      check("credit_10", 32'(fl_credit), 32'd10);

      // RS and ROB limits
      slot_valid = 3'b111; slot_dest = 3'b000; rs_free = 6'd2;
      #1 check("rs2_accept", 32'(slot_accept), 32'h3);
      rs_free = 6'd8; rob_free = 6'd1;
      #1 check("rob1_accept", 32'(slot_accept), 32'h1);
      check("rob1_stall", 32'(stall), 32'd0);
      step();
      rob_free = 6'd0;
      #1 check("rob0_accept", 32'(slot_accept), 32'h0);
      check("rob0_stall", 32'(stall), 32'd1);
      step();
      check("stallcnt_1", 32'(stall_count), 32'd1);

      // Non-contiguous valids
      rob_free = 6'd8;
      slot_valid = 3'b101;
      #1 check("v101_accept", 32'(slot_accept), 32'h1);
      slot_valid = 3'b110;
      #1 check("v110_accept", 32'(slot_accept), 32'h0);
      check("v110_stall", 32'(stall), 32'd0);

      // Credit saturates at FL_DEPTH
      slot_valid = 3'b000; retire_count = 2'd3;
      for (int i = 0; i < 8; i++) step();
      check("credit_sat", 32'(fl_credit), 32'd32);
      step();
      check("credit_sat_hold", 32'(fl_credit), 32'd32);
      retire_count = 2'd0;

      // Recover reasserted while recovering extends RECOVER
      fl_distance = 6'd40; bp_recover_en = 1'b1;
      step();
      bp_recover_en = 1'b0;
      step();
      check("ext_b_state", 32'(state), 32'd1);
      bp_recover_en = 1'b1;
      step();
      bp_recover_en = 1'b0;
      check("ext_c_state", 32'(state), 32'd1);
      step();
      check("ext_d_state", 32'(state), 32'd1);
      step();
      check("ext_resync", 32'(state), 32'd2);
      step();
      check("ext_normal", 32'(state), 32'd0);
      check("ext_credit_min", 32'(fl_credit), 32'd32);

      // Reset gates dispatch combinationally
      slot_valid = 3'b111; slot_dest = 3'b111; reset = 1'b1;
      #1 check("rst_gate_accept", 32'(slot_accept), 32'h0);
      check("rst_gate_disp", 32'(dispatch_en), 32'h0);
      reset = 1'b0; slot_valid = 3'b000; bp_recover_en = 1'b1;
      step();
      bp_recover_en = 1'b0;
      check("mid_rec_state", 32'(state), 32'd1);
      check("pre_rst_stallcnt", 32'(stall_count), 32'd1);

      // Reset in RECOVER abandons the recovery
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rst2_state", 32'(state), 32'd2);
      check("rst2_credit", 32'(fl_credit), 32'd0);
      check("rst2_stallcnt", 32'(stall_count), 32'd0);
      step();
      check("rst2_normal", 32'(state), 32'd0);
      check("rst2_credit_ld", 32'(fl_credit), 32'd32);

      // Stall counter saturation
      slot_valid = 3'b001; slot_dest = 3'b000; rob_free = 6'd0;
      for (int i = 0; i < 65534; i++) step();
      check("stallcnt_fffe", 32'(stall_count), 32'hFFFE);
      step();
      check("stallcnt_ffff", 32'(stall_count), 32'hFFFF);
      bp_recover_en = 1'b1;
      step();
      bp_recover_en = 1'b0;
      check("stallcnt_hold", 32'(stall_count), 32'hFFFF);
      check("sat_rec_state", 32'(state), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
